// File: rtl/wb_tmr_pkg.sv
// Shared constants and types for the triple-redundant Wishbone register bank.
package wb_tmr_pkg;

  localparam logic [5:0]  STATUS_IDX      = 6'h3F;
  localparam int unsigned ERR_CNT_W       = 16;
  localparam int unsigned STATUS_CNT_LSB  = 0;
  localparam int unsigned STATUS_FLAG_BIT = 16;

  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

  typedef enum logic [0:0] {
    StIdle,
    StAck
  } bus_state_e;

endpackage

// File: rtl/tmr_voter.sv
// 32-bit bitwise 2-of-3 majority voter with a disagreement flag.
module tmr_voter (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] c_i,
  output logic [31:0] voted_o,
  output logic        mismatch_o
);

  assign voted_o    = (a_i & b_i) | (b_i & c_i) | (a_i & c_i);
  assign mismatch_o = |((a_i ^ b_i) | (b_i ^ c_i));

endmodule

// File: rtl/wb_tmr_regbank.sv
// Wishbone classic slave holding TMR-protected control registers with a background
// scrubber that repairs single-copy upsets and counts the corrections.
module wb_tmr_regbank
  import wb_tmr_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned NUM_REGS  = 8,
  parameter bit          SCRUB_EN  = 1'b1
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   wbs_cyc_i,
  input  logic                   wbs_stb_i,
  input  logic                   wbs_we_i,
  input  logic [3:0]             wbs_sel_i,
  input  logic [31:0]            wbs_adr_i,
  input  logic [31:0]            wbs_dat_i,
  output logic                   wbs_ack_o,
  output logic [31:0]            wbs_dat_o,
  output logic [NUM_REGS*32-1:0] reg_q_o,
  output logic                   err_irq_o,
  output logic [ERR_CNT_W-1:0]   err_cnt_o
);

  localparam int unsigned IdxW = $clog2(NUM_REGS);

  logic [31:0] copy_a_q [NUM_REGS];
  logic [31:0] copy_b_q [NUM_REGS];
  logic [31:0] copy_c_q [NUM_REGS];
  logic [31:0] copy_a_d [NUM_REGS];
  logic [31:0] copy_b_d [NUM_REGS];
  logic [31:0] copy_c_d [NUM_REGS];
  logic [31:0] voted    [NUM_REGS];

  logic [NUM_REGS-1:0]  unused_reg_mismatch;
  logic [1:0]           unused_adr;
  bus_state_e           state_q;
  logic [IdxW-1:0]      ptr_q;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 err_flag_q, err_flag_d;
  logic                 irq_q;

  logic            hit, accept, wr_reg, idx_is_reg, err_clr;
  logic [5:0]      idx;
  logic [IdxW-1:0] reg_idx;
  logic [31:0]     rd_data;
  logic [31:0]     scrub_voted;
  logic            scrub_mismatch, scrub_fix;

  assign unused_adr = wbs_adr_i[1:0];
  assign hit        = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign accept     = (state_q == StIdle) & hit;
  assign idx        = wbs_adr_i[7:2];
  assign reg_idx    = idx[IdxW-1:0];
  assign idx_is_reg = ({26'd0, idx} < NUM_REGS);
  assign wr_reg     = accept & wbs_we_i & idx_is_reg;
  assign err_clr    = accept & wbs_we_i & (idx == STATUS_IDX) & wbs_dat_i[STATUS_FLAG_BIT];

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_vote
    tmr_voter u_voter (
      .a_i       (copy_a_q[gi]),
      .b_i       (copy_b_q[gi]),
      .c_i       (copy_c_q[gi]),
      .voted_o   (voted[gi]),
      .mismatch_o(unused_reg_mismatch[gi])
    );
    assign reg_q_o[32*gi +: 32] = voted[gi];
  end

  tmr_voter u_scrub_voter (
    .a_i       (copy_a_q[ptr_q]),
    .b_i       (copy_b_q[ptr_q]),
    .c_i       (copy_c_q[ptr_q]),
    .voted_o   (scrub_voted),
    .mismatch_o(scrub_mismatch)
  );

  // A bus write to the register under the scrub pointer takes priority over repair.
  assign scrub_fix = SCRUB_EN & scrub_mismatch & ~(wr_reg & (reg_idx == ptr_q));

  always_comb begin
    copy_a_d = copy_a_q;
    copy_b_d = copy_b_q;
    copy_c_d = copy_c_q;
    if (scrub_fix) begin
      copy_a_d[ptr_q] = scrub_voted;
      copy_b_d[ptr_q] = scrub_voted;
      copy_c_d[ptr_q] = scrub_voted;
    end
    if (wr_reg) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wbs_sel_i[b]) begin
          copy_a_d[reg_idx][8*b +: 8] = wbs_dat_i[8*b +: 8];
          copy_b_d[reg_idx][8*b +: 8] = wbs_dat_i[8*b +: 8];
          copy_c_d[reg_idx][8*b +: 8] = wbs_dat_i[8*b +: 8];
        end
      end
    end
  end

  // Clear is applied first so a detection in the same cycle still registers.
  always_comb begin
    err_cnt_d  = err_clr ? '0 : err_cnt_q;
    err_flag_d = err_clr ? 1'b0 : err_flag_q;
    if (scrub_fix) begin
      err_flag_d = 1'b1;
      if (err_cnt_d != ERR_CNT_MAX) begin
        err_cnt_d = err_cnt_d + ERR_CNT_W'(1);
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (idx_is_reg) begin
      rd_data = voted[reg_idx];
    end else if (idx == STATUS_IDX) begin
      rd_data[STATUS_CNT_LSB +: ERR_CNT_W] = err_cnt_q;
      rd_data[STATUS_FLAG_BIT]             = err_flag_q;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= StIdle;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (hit) begin
            state_q   <= StAck;
            wbs_ack_o <= 1'b1;
            if (!wbs_we_i) begin
              wbs_dat_o <= rd_data;
            end
          end
        end
        StAck: begin
          state_q   <= StIdle;
          wbs_ack_o <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        copy_a_q[i] <= '0;
        copy_b_q[i] <= '0;
        copy_c_q[i] <= '0;
      end
      ptr_q      <= '0;
      err_cnt_q  <= '0;
      err_flag_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      copy_a_q   <= copy_a_d;
      copy_b_q   <= copy_b_d;
      copy_c_q   <= copy_c_d;
      ptr_q      <= (ptr_q == IdxW'(NUM_REGS - 1)) ? '0 : ptr_q + IdxW'(1);
      err_cnt_q  <= err_cnt_d;
      err_flag_q <= err_flag_d;
      irq_q      <= scrub_fix;
    end
  end

  assign err_irq_o = irq_q;
  assign err_cnt_o = err_cnt_q;

endmodule
